uart_trx: RTL and testbench
===========================

// Module: uart_trx
// PURPOSE
//  Full-duplex 8N1 UART transceiver: independent serializer (tdata/tvld/trdy -> txd) and
//  deserializer (rxd -> rdata/rvld). Serves as the CPU's console port in fpga_top and as the
//  host-side serial model in system benches. Idle line level is high. No FIFOs, no parity.
// PARAMETERS
//  CLK_FREQ    50_000_000  clock frequency in Hz
//  BAUD_RATIO  115200      baud rate; BIT_CYC = CLK_FREQ/BAUD_RATIO (integer division, 434 at defaults)
// PORTS
//  clk    in   1  single clock domain, rising edge
//  rst_n  in   1  asynchronous, active-low reset
//  tdata  in   8  byte to transmit; sampled on accept
//  tvld   in   1  transmit request
//  trdy   out  1  transmitter idle / ready to accept
//  txd    out  1  serial output
//  rxd    in   1  serial input, asynchronous to clk
//  rvld   out  1  one-cycle pulse: rdata holds a newly received byte
//  rdata  out  8  last received byte
// BEHAVIOUR
//  Reset: txd=1, trdy=1, rvld=0, rdata=0, both FSMs IDLE, all counters 0.
//  TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - Accept when tvld & trdy at a rising edge: latch tdata; trdy=0 from the next cycle.
//   - txd=0 (start) for BIT_CYC cycles starting the cycle after accept, then tdata[0..7] LSB first,
//     each BIT_CYC cycles, then txd=1 (stop) for BIT_CYC cycles.
//   - trdy returns to 1 the cycle after the stop bit completes (frame = 10*BIT_CYC cycles).
//   - tvld while trdy=0 is ignored (not queued); tdata changes after accept have no effect.
//   - Back-to-back: a tvld on the first trdy=1 cycle starts the next frame with no idle gap
//     beyond that one cycle.
//  RX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - rxd passes through a 2-flop synchronizer; FSM uses the synchronized value only.
//   - IDLE: synchronized rxd low -> START, counter cleared.
//   - START: after BIT_CYC/2 cycles re-sample; if high (glitch) -> IDLE with no output;
//     else -> DATA.
//   - DATA: sample every BIT_CYC cycles (mid-bit), shift LSB first, 8 bits.
//   - STOP: sample after BIT_CYC more cycles. If 1: rdata <= byte, rvld=1 for exactly that
//     one cycle, then IDLE. If 0 (framing error): byte discarded, rvld stays 0, rdata
//     unchanged, then IDLE, which waits for rxd high before arming a new start.
//   - Return to IDLE at mid-stop-bit so the next start edge is caught even at full line rate.
//   - rdata holds its value until the next valid frame.
//  TX and RX are fully independent; simultaneous activity and loopback txd->rxd are legal.
//  Asynchronous reset mid-frame aborts both directions immediately to reset values;
//  no partial byte is reported.
//  Counters sized to $clog2(BIT_CYC)+1 bits; bit index 3 bits.
// STRUCTURE
//  Package uart_pkg: TX/RX state enum (IDLE, START, DATA, STOP), localparam BIT_CYC,
//   HALF_CYC=BIT_CYC/2.
//  Natural sub-module: uart_rx_eng (synchronizer + RX FSM); TX FSM sits inline in uart_trx.
// TESTING (loopback rxd=txd unless noted; default params, BIT_CYC=434)
//  1 Send 0x68 ('h') -> trdy low 4340 cycles; txd pattern 0,0,0,0,1,0,1,1,0,1;
//    rvld pulses once with rdata=0x68.
//  2 Send "help\n" on each trdy rise -> rvld sequence 0x68,0x65,0x6C,0x70,0x0A; no byte lost.
//  3 rxd low pulse of 100 cycles, RX external -> no rvld; next valid 0x41 frame received.
//  4 External frame 0x55 with stop bit 0 -> no rvld; rdata keeps prior value;
//    following 0x33 frame received.
//  5 tvld=1 with 0xAA while busy sending 0x11 -> only 0x11 sent; trdy stays low until
//    frame end.
//  6 rst_n low mid-data-bit -> txd=1, trdy=1, rvld=0, rdata=0 at once; fresh 0x7E frame
//    after release OK.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transceiver: FSM state encoding and default timing.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_st_e;

    localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
    localparam int unsigned BAUD_RATIO_DEF = 115200;
    localparam int unsigned BIT_CYC        = CLK_FREQ_DEF / BAUD_RATIO_DEF;
    localparam int unsigned HALF_CYC       = BIT_CYC / 2;

    function automatic int unsigned cnt_width(input int unsigned cyc);
        return $clog2(cyc) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_eng.sv
// UART receive engine: 2-flop synchronizer plus mid-bit sampling RX FSM.
module uart_rx_eng
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYC_P = BIT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rvld,
    output logic [7:0] rdata
);

    localparam int unsigned CntW = cnt_width(BIT_CYC_P);
    localparam int unsigned HalfCyc = (BIT_CYC_P / 2 > 0) ? BIT_CYC_P / 2 : 1;
    localparam logic [CntW-1:0] BitLast = CntW'(BIT_CYC_P - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfCyc - 1);

    logic [1:0]      r_sync;
    uart_st_e        r_st, w_st_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [2:0]      r_bit, w_bit_d;
    logic [7:0]      r_sh, w_sh_d;
    logic [7:0]      r_rdata, w_rdata_d;
    logic            r_rvld, w_rvld_d;
    logic            r_wait, w_wait_d;
    logic            w_rx;

    assign w_rx  = r_sync[1];
    assign rvld  = r_rvld;
    assign rdata = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_st    <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_rdata <= '0;
            r_rvld  <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rxd};
            r_st    <= w_st_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_sh    <= w_sh_d;
            r_rdata <= w_rdata_d;
            r_rvld  <= w_rvld_d;
            r_wait  <= w_wait_d;
        end
    end

    always_comb begin
        w_st_d    = r_st;
        w_cnt_d   = r_cnt + 1'b1;
        w_bit_d   = r_bit;
        w_sh_d    = r_sh;
        w_rdata_d = r_rdata;
        w_rvld_d  = 1'b0;
        w_wait_d  = r_wait;
        case (r_st)
            StIdle: begin
                w_cnt_d = '0;
                // After a framing error the line must go high before a new start is armed.
                if (w_rx) begin
                    w_wait_d = 1'b0;
                end else if (!r_wait) begin
                    w_st_d = StStart;
                end
            end
            StStart: begin
                if (r_cnt == HalfLast) begin
                    w_cnt_d = '0;
                    w_bit_d = '0;
                    w_st_d  = w_rx ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == BitLast) begin
                    w_cnt_d = '0;
                    w_sh_d  = {w_rx, r_sh[7:1]};
                    w_bit_d = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_st_d = StStop;
                    end
                end
            end
            StStop: begin
                if (r_cnt == BitLast) begin
                    w_cnt_d = '0;
                    w_st_d  = StIdle;
                    if (w_rx) begin
                        w_rdata_d = r_sh;
                        w_rvld_d  = 1'b1;
                    end else begin
                        w_wait_d = 1'b1;
                    end
                end
            end
            default: w_st_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART: inline TX serializer and uart_rx_eng deserializer, independent paths.
module uart_trx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD_RATIO = BAUD_RATIO_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tdata,
    input  logic       tvld,
    output logic       trdy,
    output logic       txd,
    input  logic       rxd,
    output logic       rvld,
    output logic [7:0] rdata
);

    localparam int unsigned BitCyc = CLK_FREQ / BAUD_RATIO;
    localparam int unsigned CntW = cnt_width(BitCyc);
    localparam logic [CntW-1:0] BitLast = CntW'(BitCyc - 1);

    uart_st_e        r_tx_st, w_tx_st_d;
    logic [CntW-1:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]      r_tx_bit, w_tx_bit_d;
    logic [7:0]      r_tx_sh, w_tx_sh_d;
    logic            w_bit_end;

    assign w_bit_end = (r_tx_cnt == BitLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_st  <= StIdle;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else begin
            r_tx_st  <= w_tx_st_d;
            r_tx_cnt <= w_tx_cnt_d;
            r_tx_bit <= w_tx_bit_d;
            r_tx_sh  <= w_tx_sh_d;
        end
    end

    always_comb begin
        w_tx_st_d  = r_tx_st;
        w_tx_cnt_d = w_bit_end ? '0 : r_tx_cnt + 1'b1;
        w_tx_bit_d = r_tx_bit;
        w_tx_sh_d  = r_tx_sh;
        trdy       = 1'b0;
        txd        = 1'b1;
        case (r_tx_st)
            StIdle: begin
                trdy       = 1'b1;
                w_tx_cnt_d = '0;
                if (tvld) begin
                    w_tx_st_d  = StStart;
                    w_tx_sh_d  = tdata;
                    w_tx_bit_d = '0;
                end
            end
            StStart: begin
                txd = 1'b0;
                if (w_bit_end) begin
                    w_tx_st_d = StData;
                end
            end
            StData: begin
                txd = r_tx_sh[0];
                if (w_bit_end) begin
                    w_tx_sh_d  = {1'b0, r_tx_sh[7:1]};
                    w_tx_bit_d = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_st_d = StStop;
                    end
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_tx_st_d = StIdle;
                end
            end
            default: w_tx_st_d = StIdle;
        endcase
    end

    uart_rx_eng #(
        .BIT_CYC_P(BitCyc)
    ) u_rx_eng (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .rvld (rvld),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx: loopback frames from a vector table plus external RX corner cases.
module tb_uart_trx;

    localparam int BC = 434;
    localparam int HC = 217;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvld = 1'b0;
    logic       trdy;
    logic       txd;
    logic       rxd;
    logic       rvld;
    logic [7:0] rdata;
    logic       ext_mode = 1'b0;
    logic       ext_rxd = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit k = txd during bit slot k (start first, stop last)
        logic       poke;   // raise tvld/tdata=0xAA while busy
    } vec_t;

    vec_t vecs[6];

    assign rxd = ext_mode ? ext_rxd : txd;

    always #5 clk = ~clk;

    uart_trx dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tdata(tdata),
        .tvld (tvld),
        .trdy (trdy),
        .txd  (txd),
        .rxd  (rxd),
        .rvld (rvld),
        .rdata(rdata)
    );

    always @(negedge clk) begin
        if (rvld) rx_q.push_back(rdata);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_vec(input vec_t v);
        int n;
        int q0;
        logic [9:0] cap;
        n = 0;
        while (!trdy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", int'(trdy), 1);
        q0 = rx_q.size();
        cap = '0;
        tdata = v.data;
        tvld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvld = 1'b0;
        n = 1;
        while (n < 5000) begin
            if ((n % BC) == HC && (n / BC) < 10) cap[n / BC] = txd;
            if (v.poke) begin
                if (n == 5) tdata = 8'hAA;
                if (n == 1000) tvld = 1'b1;
                if (n == 4000) tvld = 1'b0;
            end
            if (trdy) break;
            @(negedge clk);
            n++;
        end
        check("trdy_low_cycles", n - 1, 10 * BC);
        check("txd_frame", int'(cap), int'(v.frame));
        check("rx_count", rx_q.size() - q0, 1);
        if (rx_q.size() > q0) check("rx_byte", int'(rx_q[q0]), int'(v.data));
        check("rdata_hold", int'(rdata), int'(v.data));
    endtask

    task automatic ext_frame(input logic [7:0] data, input logic stop);
        ext_rxd = 1'b0;
        repeat (BC) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            ext_rxd = data[k];
            repeat (BC) @(negedge clk);
        end
        ext_rxd = stop;
        repeat (BC) @(negedge clk);
        ext_rxd = 1'b1;
    endtask

    initial begin
        int q0;
        vec_t v7e;
        vecs[0] = '{8'h68, 10'b1_0110_1000_0, 1'b0};
        vecs[1] = '{8'h65, 10'b1_0110_0101_0, 1'b0};
        vecs[2] = '{8'h6C, 10'b1_0110_1100_0, 1'b0};
        vecs[3] = '{8'h70, 10'b1_0111_0000_0, 1'b0};
        vecs[4] = '{8'h0A, 10'b1_0000_1010_0, 1'b0};
        vecs[5] = '{8'h11, 10'b1_0001_0001_0, 1'b1};
        v7e     = '{8'h7E, 10'b1_0111_1110_0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_txd", int'(txd), 1);
        check("reset_trdy", int'(trdy), 1);
        check("reset_rvld", int'(rvld), 0);
        check("reset_rdata", int'(rdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback frames, back-to-back on each trdy rise; last one ignores a busy-time request.
        for (int i = 0; i < 6; i++) send_vec(vecs[i]);
        q0 = rx_q.size();
        repeat (500) @(negedge clk);
        check("ignored_req_trdy", int'(trdy), 1);
        check("ignored_req_txd", int'(txd), 1);
        check("ignored_req_rx", rx_q.size() - q0, 0);

        // External RX: short glitch, then a valid frame.
        ext_mode = 1'b1;
        repeat (10) @(negedge clk);
        q0 = rx_q.size();
        ext_rxd = 1'b0;
        repeat (100) @(negedge clk);
        ext_rxd = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_rvld", rx_q.size() - q0, 0);
        ext_frame(8'h41, 1'b1);
        repeat (10) @(negedge clk);
        check("ext41_count", rx_q.size() - q0, 1);
        check("ext41_rdata", int'(rdata), 8'h41);

        // Framing error is discarded, next frame still received.
        q0 = rx_q.size();
        ext_frame(8'h55, 1'b0);
        repeat (1000) @(negedge clk);
        check("frame_err_no_rvld", rx_q.size() - q0, 0);
        check("frame_err_rdata", int'(rdata), 8'h41);
        ext_frame(8'h33, 1'b1);
        repeat (10) @(negedge clk);
        check("ext33_count", rx_q.size() - q0, 1);
        check("ext33_rdata", int'(rdata), 8'h33);

        // Asynchronous reset mid data bit.
        ext_mode = 1'b0;
        repeat (10) @(negedge clk);
        q0 = rx_q.size();
        tdata = 8'h5A;
        tvld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tvld = 1'b0;
        repeat (3 * BC + 100) @(negedge clk);
        check("busy_before_reset", int'(trdy), 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_txd", int'(txd), 1);
        check("arst_trdy", int'(trdy), 1);
        check("arst_rvld", int'(rvld), 0);
        check("arst_rdata", int'(rdata), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("arst_no_partial", rx_q.size() - q0, 0);
        send_vec(v7e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
